// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the IF-stage fetch queue: bus widths, FSM encodings,
// default queue depth and the queued {pc, inst} entry layout.
package if_fetch_queue_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;
  localparam int unsigned RegBus      = 32;

  localparam int unsigned     IfFifoDepth = 4;
  localparam logic [InstBus-1:0] NopInst  = 32'h0;

  typedef enum logic [1:0] {
    IfIdle    = 2'b00,
    IfWait    = 2'b01,
    IfDiscard = 2'b10
  } if_state_e;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// Synchronous FIFO of fetched {pc, inst} entries with push/pop/clear.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module if_fifo
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IfFifoDepth,
  parameter int unsigned PTR_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [PTR_W:0] count
);

  fetch_entry_t   mem [DEPTH];
  logic [PTR_W:0] wr_q, rd_q;
  logic           do_push, do_pop;

  assign full    = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign empty   = (wr_q == rd_q);
  assign count   = wr_q - rd_q;
  assign head    = mem[rd_q[PTR_W-1:0]];
  // A simultaneous pop makes room, so a push into a full queue is accepted.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clear) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_q[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// IF-stage fetch engine: issues single outstanding imem requests, queues
// returned {pc, inst} pairs and feeds IF/ID. IF_FETCH_PERF_EN adds perf counters.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IfFifoDepth,
  parameter int unsigned PTR_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [InstAddrBus-1:0] pc,
  input  logic [5:0]             stall,
  input  logic                   flush,
  output logic                   imem_req,
  output logic [InstAddrBus-1:0] imem_addr,
  input  logic                   imem_ack,
  input  logic [InstBus-1:0]     imem_rdata,
  output logic [InstAddrBus-1:0] id_pc,
  output logic [InstBus-1:0]     id_inst,
  output logic                   id_valid,
  output logic                   stallreq_if
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [RegBus-1:0]      perf_wait_cycles,
  output logic [15:0]            perf_flush_drops
`endif
);

  if_state_e              state_q, state_d;
  logic                   req_q, req_d;
  logic [InstAddrBus-1:0] addr_q, addr_d;
  logic                   push, pop;
  logic                   fifo_full, fifo_empty;
  logic [PTR_W:0]         fifo_count;
  fetch_entry_t           head, push_data;
  logic                   unused_stall;

  assign unused_stall = ^{stall[5:2], stall[0]};
  assign imem_req     = req_q;
  assign imem_addr    = addr_q;
  assign push_data    = '{pc: addr_q, inst: imem_rdata};
  assign pop          = !flush && !stall[1] && !fifo_empty;

  if_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IfIdle;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    push        = 1'b0;
    stallreq_if = 1'b0;
    case (state_q)
      IfIdle: begin
        stallreq_if = fifo_full;
        if (ce && !flush && (!fifo_full || pop)) begin
          state_d = IfWait;
          req_d   = 1'b1;
          addr_d  = pc;
        end
      end
      IfWait: begin
        stallreq_if = !imem_ack;
        if (imem_ack) begin
          state_d = IfIdle;
          req_d   = 1'b0;
          push    = !flush;
        end else if (flush) begin
          state_d = IfDiscard;
          req_d   = 1'b0;
        end
      end
      IfDiscard: begin
        stallreq_if = 1'b1;
        if (imem_ack) state_d = IfIdle;
      end
      default: begin
        state_d = IfIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc    <= '0;
      id_inst  <= NopInst;
      id_valid <= 1'b0;
    end else if (flush) begin
      id_inst  <= NopInst;
      id_valid <= 1'b0;
    end else if (!stall[1]) begin
      if (!fifo_empty) begin
        id_pc    <= head.pc;
        id_inst  <= head.inst;
        id_valid <= 1'b1;
      end else begin
        id_inst  <= NopInst;
        id_valid <= 1'b0;
      end
    end
  end

`ifdef IF_FETCH_PERF_EN
  // Drops on flush: everything queued plus the request still in flight.
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, perf_flush_drops} + 17'(fifo_count) + 17'(state_q == IfWait);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_wait_cycles <= '0;
      perf_flush_drops <= '0;
    end else begin
      if (stallreq_if && (perf_wait_cycles != '1))
        perf_wait_cycles <= perf_wait_cycles + 1'b1;
      if (flush)
        perf_flush_drops <= drop_sum[16] ? '1 : drop_sum[15:0];
    end
  end
`else
  logic unused_fifo_count;
  assign unused_fifo_count = ^fifo_count;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue with hand-computed expectations.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] pc;
  logic [5:0]  stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        stallreq_if;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_wait_cycles;
  logic [15:0] perf_flush_drops;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .pc          (pc),
    .stall       (stall),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .id_pc       (id_pc),
    .id_inst     (id_inst),
    .id_valid    (id_valid),
    .stallreq_if (stallreq_if)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_wait_cycles (perf_wait_cycles),
    .perf_flush_drops (perf_flush_drops)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hA500_0000 | a;
  endfunction

  initial begin
    rst = 1'b0; ce = 1'b0; pc = '0; stall = '0; flush = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;

    // Reset values
    tick();
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_id_pc", id_pc, 0);
    check("rst_id_inst", id_inst, 0);
    check("rst_id_valid", id_valid, 0);
    check("rst_stallreq", stallreq_if, 0);
    tick();
    rst = 1'b1;
    tick();

    // Single-cycle memory on pc 0x00
    ce = 1'b1; pc = 32'h0;
    tick();
    check("t1_req", imem_req, 1);
    check("t1_addr", imem_addr, 32'h0);
    ce = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h3401_0011;
    #1 check("t1_stall_ack", stallreq_if, 0);
    tick();
    imem_ack = 1'b0;
    check("t1_req_drop", imem_req, 0);
    check("t1_not_yet", id_valid, 0);
    tick();
    check("t1_valid", id_valid, 1);
    check("t1_id_pc", id_pc, 32'h0);
    check("t1_id_inst", id_inst, 32'h3401_0011);
    tick();
    check("t1_empty_valid", id_valid, 0);
    check("t1_empty_inst", id_inst, 0);

    // Three-cycle latency on pc 0x04
    ce = 1'b1; pc = 32'h4;
    tick();
    ce = 1'b0;
    check("t2_stall_w1", stallreq_if, 1);
    check("t2_addr_w1", imem_addr, 32'h4);
    tick();
    check("t2_stall_w2", stallreq_if, 1);
    check("t2_addr_w2", imem_addr, 32'h4);
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
    #1 check("t2_stall_ack", stallreq_if, 0);
    check("t2_addr_ack", imem_addr, 32'h4);
    tick();
    imem_ack = 1'b0;
    tick();
    check("t2_valid", id_valid, 1);
    check("t2_id_pc", id_pc, 32'h4);
    check("t2_id_inst", id_inst, 32'h1111_2222);
`ifdef IF_FETCH_PERF_EN
    check("perf_wait", perf_wait_cycles, 2);
`endif

    // Fill the queue while ID holds, then drain in order
    stall = 6'b00_0010;
    for (int i = 0; i < 4; i++) begin
      ce = 1'b1; pc = 32'h8 + 32'(4 * i);
      tick();
      ce = 1'b0; imem_ack = 1'b1; imem_rdata = inst_of(pc);
      tick();
      imem_ack = 1'b0;
    end
    check("t3_full_stall", stallreq_if, 1);
    check("t3_full_noreq", imem_req, 0);
    ce = 1'b1; pc = 32'h18;
    tick();
    check("t3_blocked_req", imem_req, 0);
    check("t3_blocked_stall", stallreq_if, 1);
    check("t3_held_pc", id_pc, 32'h4);
    stall = '0;
    tick();
    check("t3_pop0_pc", id_pc, 32'h8);
    check("t3_pop0_inst", id_inst, inst_of(32'h8));
    check("t3_issue_req", imem_req, 1);
    check("t3_issue_addr", imem_addr, 32'h18);
    ce = 1'b0; imem_ack = 1'b1; imem_rdata = inst_of(32'h18);
    for (int j = 1; j <= 4; j++) begin
      tick();
      imem_ack = 1'b0;
      check("t3_order_pc", id_pc, 32'h8 + 32'(4 * j));
      check("t3_order_inst", id_inst, inst_of(32'h8 + 32'(4 * j)));
      check("t3_order_valid", id_valid, 1);
    end
    tick();
    check("t3_drained", id_valid, 0);

    // Flush during WAIT, stale ack dropped, then redirect fetch
    ce = 1'b1; pc = 32'h20;
    tick();
    ce = 1'b0; flush = 1'b1;
    #1 check("t4_flush_stall", stallreq_if, 1);
    tick();
    flush = 1'b0; ce = 1'b1; pc = 32'h180;
    check("t4_discard_stall", stallreq_if, 1);
    check("t4_discard_noreq", imem_req, 0);
    tick();
    check("t4_no_early_issue", imem_req, 0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1 check("t4_stale_stall", stallreq_if, 1);
    tick();
    imem_ack = 1'b0;
    check("t4_idle_noreq", imem_req, 0);
    check("t4_no_stale_valid", id_valid, 0);
    tick();
    check("t4_new_req", imem_req, 1);
    check("t4_new_addr", imem_addr, 32'h180);
    ce = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h2000_0180;
    tick();
    imem_ack = 1'b0;
    check("t4_no_stale_inst", id_inst, 0);
    tick();
    check("t4_id_pc", id_pc, 32'h180);
    check("t4_id_inst", id_inst, 32'h2000_0180);
`ifdef IF_FETCH_PERF_EN
    check("perf_drops", perf_flush_drops, 1);
`endif

    // Asynchronous reset in WAIT with two entries queued
    stall = 6'b00_0010;
    for (int i = 0; i < 2; i++) begin
      ce = 1'b1; pc = 32'h40 + 32'(4 * i);
      tick();
      ce = 1'b0; imem_ack = 1'b1; imem_rdata = inst_of(pc);
      tick();
      imem_ack = 1'b0;
    end
    ce = 1'b1; pc = 32'h48;
    tick();
    ce = 1'b0;
    check("t5_pre_req", imem_req, 1);
    check("t5_pre_stall", stallreq_if, 1);
    #2 rst = 1'b0;
    #1;
    check("t5_async_req", imem_req, 0);
    check("t5_async_addr", imem_addr, 0);
    check("t5_async_id_pc", id_pc, 0);
    check("t5_async_valid", id_valid, 0);
    check("t5_async_stall", stallreq_if, 0);
    tick();
    rst = 1'b1; stall = '0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_ack = 1'b0;
    check("t5_ack_ignored_req", imem_req, 0);
    tick();
    check("t5_ack_ignored_valid", id_valid, 0);
    check("t5_ack_ignored_inst", id_inst, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
